fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain for the 8-bit byte FIFO: pops one byte whenever the FIFO is non-empty
//  and serialises it as an asynchronous UART frame on txd.
//  Frame: start bit, 8 data bits LSB first, optional parity bit, STOP_BITS stop bits.
//  Sits between the FIFO read port and the board TX pin; single clock domain.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous reset, active-high
//  fifo_data   in   8  FIFO registered read data; valid the cycle after a fifo_rd_en pulse
//  fifo_empty  in   1  FIFO empty flag
//  fifo_rd_en  out  1  FIFO pop strobe; one-cycle pulse per byte
//  tx_en       in   1  enables starting new frames; a frame in flight always completes
//  txd         out  1  serial line; idles high
//  busy        out  1  high from FETCH through the end of the last stop bit
//  tx_done     out  1  one-cycle pulse in the final clk of the last stop bit
// BEHAVIOUR
//  - Clocking and reset: one clock (clk). Reset is synchronous, active-high (rst).
//  - Reset values: state=IDLE, txd=1, fifo_rd_en=0, busy=0, tx_done=0.
//    Baud counter, bit index and shift register are all cleared.
//  - FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (UART_PARITY_EN only), STOP.
//    IDLE   -> FETCH when tx_en && !fifo_empty. fifo_empty and tx_en are sampled only in IDLE.
//    FETCH  -> LOAD after 1 cycle. fifo_rd_en=1 in this state only (Moore output).
//    LOAD   -> START after 1 cycle. fifo_data is captured into the shift register at the end of LOAD.
//    START  -> DATA. txd=0 for CLKS_PER_BIT cycles.
//    DATA   -> PARITY/STOP after bit 7. txd=shreg[0]; shift right every CLKS_PER_BIT cycles; 8 bits total.
//    PARITY -> STOP. txd=^byte (even parity) for CLKS_PER_BIT cycles.
//    STOP   -> IDLE. txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  - Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
//    Clears on every bit boundary and on entry to START.
//  - txd is registered; it changes only on bit boundaries or on reset.
//  - Latency: IDLE-with-data to txd falling edge = 3 clk (IDLE, FETCH, LOAD).
//  - Back-to-back: the FSM always passes through IDLE after STOP. Minimum idle-high gap
//    between frames is therefore 3 clk beyond the stop bits.
//  - Exactly one fifo_rd_en pulse per frame; never asserted while fifo_empty=1 is seen in IDLE.
//  - tx_en falling mid-frame: the current frame completes; no further fetch.
//  - rst mid-frame: the next edge forces txd=1 and state=IDLE. A byte already popped is
//    discarded, not retransmitted.
//  - Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT clk, plus CLKS_PER_BIT with parity.
// CONFIGURATION
//  UART_PARITY_EN defined:
//    - PARITY state is compiled in; an even-parity bit is sent after data bit 7.
//  UART_PARITY_EN undefined:
//    - No PARITY state or parity logic; DATA goes directly to STOP.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1. FIFO holds 0x55, tx_en=1
//     -> one fifo_rd_en pulse; txd bits 0,1,0,1,0,1,0,1,0,1 at 4 clk each;
//        tx_done pulses at clk 40 of the frame.
//  2. fifo_empty=1, tx_en=1 for 100 clk
//     -> fifo_rd_en stays 0, txd=1, busy=0.
//  3. FIFO holds 0xA5 then 0x3C
//     -> two frames with data LSB-first 1010_0101 then 0011_1100;
//        exactly 3 clk of txd=1 after the first stop bit ends.
//  4. UART_PARITY_EN defined: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0;
//     frame is 44 clk.
//  5. tx_en dropped during DATA with FIFO still non-empty
//     -> frame finishes, then IDLE; no further rd_en.
//     Re-raising tx_en resumes with the next byte.
//  6. rst asserted during DATA bit 3
//     -> next clk: txd=1, busy=0, tx_done=0.
//     After release, the next queued byte sends a full frame.
//     STOP_BITS=2 run: the stop phase lasts 8 clk.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-drain UART transmitter: pops a byte, sends start/8 data/[parity]/stop bits on txd.
// Optional even-parity bit after data bit 7 when UART_PARITY_EN is defined.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_rd_en,
   input  logic       tx_en,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shreg_q;
   logic            txd_q;
   logic            bit_end;
`ifdef UART_PARITY_EN
   logic            parity_q;
`endif

   assign bit_end = (cnt_q == CNT_MAX);
   assign txd     = txd_q;
   assign busy    = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      tx_done    = 1'b0;
      case (state_q)
         IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
         FETCH: begin
            fifo_rd_en = 1'b1;
            state_d    = LOAD;
         end
         LOAD:  state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA: begin
`ifdef UART_PARITY_EN
            if (bit_end && bit_idx_q == 3'd7) state_d = PARITY;
`else
            if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
`endif
         end
`ifdef UART_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: begin
            if (bit_end && bit_idx_q == STOP_LAST) begin
               state_d = IDLE;
               tx_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // txd is loaded one bit ahead so it changes exactly on bit boundaries
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
`ifdef UART_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            LOAD: begin
               shreg_q   <= fifo_data;
               cnt_q     <= '0;
               bit_idx_q <= '0;
               txd_q     <= 1'b0;
`ifdef UART_PARITY_EN
               parity_q  <= ^fifo_data;
`endif
            end
            START: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  txd_q <= shreg_q[0];
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_q <= '0;
`ifdef UART_PARITY_EN
                     txd_q     <= parity_q;
`else
                     txd_q     <= 1'b1;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     shreg_q   <= shreg_q >> 1;
                     txd_q     <= shreg_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  txd_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt_q     <= '0;
                  bit_idx_q <= (bit_idx_q == STOP_LAST) ? 3'd0 : bit_idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q <= '0;
               txd_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
